// File: rtl/axis_fifo_pkg.sv
// Shared types and helpers for the AXI-Stream packet FIFO.
// The DROP write state exists only when AXIS_PKT_FIFO_DROP_EN is defined.
package axis_fifo_pkg;

`ifdef AXIS_PKT_FIFO_DROP_EN
    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_ACTIVE = 2'd1,
        WR_DROP   = 2'd2
    } wr_state_e;
`else
    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_ACTIVE = 2'd1
    } wr_state_e;
`endif

    // One extra bit beyond the address distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage for the packet FIFO: registered write, combinational read.
module axis_fifo_ram #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream packet FIFO with store-and-forward or cut-through read release.
// Define AXIS_PKT_FIFO_DROP_EN to discard packets that overflow instead of backpressuring.
module axis_pkt_fifo
    import axis_fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int DEPTH            = 2048,
    parameter int PROG_FULL_THRESH = DEPTH - 1500,
    parameter int PKT_MODE         = 1
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [31:0]           axis_wr_data_count,
    output logic [31:0]           axis_rd_pkt_count,
    output logic                  prog_full,
    output logic                  pkt_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);

    wr_state_e              state_r;
    logic [PW-1:0]          wr_ptr_c_r;
    logic [PW-1:0]          wr_ptr_t_r;
    logic [PW-1:0]          rd_ptr_r;
    logic [PW-1:0]          pkt_count_r;
    logic [PW-1:0]          used_s;
    logic                   full_s;
    logic                   empty_s;
    logic                   wr_en_s;
    logic                   rd_en_s;
    logic                   commit_s;
    logic                   pkt_rd_s;
    logic                   fwd_s;
    logic [DATA_WIDTH:0]    rd_word_s;

    assign used_s   = wr_ptr_t_r - rd_ptr_r;
    assign full_s   = (used_s == PTR_DEPTH);
    assign empty_s  = (used_s == PTR_ZERO);
    assign rd_en_s  = m_axis_tvalid && m_axis_tready;
    assign pkt_rd_s = rd_en_s && m_axis_tlast;
    assign commit_s = wr_en_s && s_axis_tlast;

`ifdef AXIS_PKT_FIFO_DROP_EN
    logic pkt_drop_r;

    assign fwd_s    = 1'b0;
    assign pkt_drop = pkt_drop_r;

    // Write acceptance: DROP swallows words without storing them.
    always_comb begin
        if (state_r == WR_DROP) begin
            s_axis_tready = 1'b1;
            wr_en_s       = 1'b0;
        end else begin
            s_axis_tready = !full_s;
            wr_en_s       = s_axis_tvalid && !full_s;
        end
    end
`else
    logic force_s;
    logic cut_r;

    assign pkt_drop      = 1'b0;
    assign s_axis_tready = !full_s;
    assign wr_en_s       = s_axis_tvalid && !full_s;
    // A packet larger than the FIFO can never commit, so release it early.
    assign force_s = (PKT_MODE == 1) && (state_r == WR_ACTIVE) && full_s && (pkt_count_r == PTR_ZERO);
    assign fwd_s   = force_s || cut_r;

    // Forced cut-through stays in effect until the oversized packet commits.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            cut_r <= 1'b0;
        end else if (commit_s) begin
            cut_r <= 1'b0;
        end else if (force_s) begin
            cut_r <= 1'b1;
        end
    end
`endif

    // Write FSM and write-side pointers.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_r    <= WR_IDLE;
            wr_ptr_t_r <= PTR_ZERO;
            wr_ptr_c_r <= PTR_ZERO;
`ifdef AXIS_PKT_FIFO_DROP_EN
            pkt_drop_r <= 1'b0;
`endif
        end else begin
`ifdef AXIS_PKT_FIFO_DROP_EN
            pkt_drop_r <= 1'b0;
`endif
            if (wr_en_s) begin
                wr_ptr_t_r <= wr_ptr_t_r + PTR_ONE;
            end
            if (commit_s) begin
                wr_ptr_c_r <= wr_ptr_t_r + PTR_ONE;
            end
            case (state_r)
                WR_IDLE: begin
                    if (wr_en_s && !s_axis_tlast) begin
                        state_r <= WR_ACTIVE;
                    end
                end
                WR_ACTIVE: begin
                    if (commit_s) begin
                        state_r <= WR_IDLE;
`ifdef AXIS_PKT_FIFO_DROP_EN
                    end else if (full_s && (PKT_MODE == 1)) begin
                        state_r <= WR_DROP;
`endif
                    end
                end
`ifdef AXIS_PKT_FIFO_DROP_EN
                WR_DROP: begin
                    // Rewind the tail over the partial packet once its tlast is swallowed.
                    if (s_axis_tvalid && s_axis_tlast) begin
                        wr_ptr_t_r <= wr_ptr_c_r;
                        pkt_drop_r <= 1'b1;
                        state_r    <= WR_IDLE;
                    end
                end
`endif
                default: state_r <= WR_IDLE;
            endcase
        end
    end

    // Read pointer and committed-packet count.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            rd_ptr_r    <= PTR_ZERO;
            pkt_count_r <= PTR_ZERO;
        end else begin
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({commit_s, pkt_rd_s})
                2'b10:   pkt_count_r <= pkt_count_r + PTR_ONE;
                2'b01:   pkt_count_r <= pkt_count_r - PTR_ONE;
                default: pkt_count_r <= pkt_count_r;
            endcase
        end
    end

    // Read release: committed data only, unless cut-through applies.
    always_comb begin
        if (PKT_MODE == 0) begin
            m_axis_tvalid = !empty_s;
        end else if (fwd_s) begin
            m_axis_tvalid = (rd_ptr_r != wr_ptr_t_r);
        end else begin
            m_axis_tvalid = (rd_ptr_r != wr_ptr_c_r);
        end
    end

    axis_fifo_ram #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (s_axis_aclk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_t_r[AW-1:0]),
        .wr_data ({s_axis_tlast, s_axis_tdata}),
        .rd_addr (rd_ptr_r[AW-1:0]),
        .rd_data (rd_word_s)
    );

    assign m_axis_tdata       = rd_word_s[DATA_WIDTH-1:0];
    assign m_axis_tlast       = rd_word_s[DATA_WIDTH];
    assign axis_wr_data_count = 32'(used_s);
    assign axis_rd_pkt_count  = 32'(pkt_count_r);
    assign prog_full          = (int'(used_s) > PROG_FULL_THRESH);

endmodule
